// File: rtl/dom_rand_pkg.sv
// Shared types, constants and width helpers for the DOM randomness source.
// The optional health monitor is enabled with DOM_RAND_HEALTH_EN.
package dom_rand_pkg;

    typedef enum logic [1:0] {
        ST_SEED  = 2'd0,
        ST_WARM  = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } dom_rand_state_e;

    localparam int XS_SHL_A = 13;
    localparam int XS_SHR_B = 17;
    localparam int XS_SHL_C = 5;

    // Substituted for an all-zero seed word, which is the xorshift fixed point.
    localparam logic [31:0] ZERO_SEED_SUB = 32'h2545F491;

    function automatic int nb(input int shares, input int foo);
        return (foo == 1 && shares == 2) ? 1 : shares;
    endfunction

    function automatic int rw(input int shares, input int foo);
        return 5 * shares * (shares - 1) + 4 * nb(shares, foo);
    endfunction

    function automatic int nl(input int shares, input int foo);
        return (rw(shares, foo) + 31) / 32;
    endfunction

    function automatic logic [31:0] xs32_step(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << XS_SHL_A);
        y = y ^ (y >> XS_SHR_B);
        y = y ^ (y << XS_SHL_C);
        return y;
    endfunction

endpackage

// File: rtl/dom_xorshift32_lane.sv
// One 32-bit xorshift32 lane: seed load, single-step advance, and (with
// DOM_RAND_HEALTH_EN) a stuck-advance detector.
module dom_xorshift32_lane
    import dom_rand_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_en_i,
    input  logic [31:0] load_val_i,
    input  logic        adv_en_i,
    output logic [31:0] lane_o,
    output logic        health_err_o
);

    logic [31:0] lane_q;
    logic [31:0] lane_d;
    logic [31:0] adv_val;

    assign adv_val = xs32_step(lane_q);

    always_comb begin
        lane_d = lane_q;
        if (load_en_i) begin
            lane_d = (load_val_i == 32'h0) ? ZERO_SEED_SUB : load_val_i;
        end else if (adv_en_i) begin
            lane_d = adv_val;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lane_q <= 32'h0;
        end else begin
            lane_q <= lane_d;
        end
    end

    assign lane_o = lane_q;

`ifdef DOM_RAND_HEALTH_EN
    // An advance that returns the pre-advance value means the lane is stuck.
    assign health_err_o = adv_en_i && (adv_val == lane_q);
`else
    assign health_err_o = 1'b0;
`endif

endmodule

// File: rtl/dom_rand_source.sv
// Randomness source for the DOM S-box: NL xorshift32 lanes mapped onto the
// B/Z/Z1/Z2 bundles. Define DOM_RAND_HEALTH_EN to build the stuck-lane monitor.
module dom_rand_source
    import dom_rand_pkg::*;
#(
    parameter int SHARES                   = 2,
    parameter int FIRST_ORDER_OPTIMIZATION = 1,
    parameter int RESEED_INTERVAL          = 1024,
    parameter int WARMUP                   = 4
) (
    input  logic                                        ClkxCI,
    input  logic                                        RstxRI,
    input  logic [31:0]                                 SeedxDI,
    input  logic                                        SeedValidxSI,
    output logic                                        SeedReadyxSO,
    input  logic                                        ReseedxSI,
    output logic                                        RndValidxSO,
    input  logic                                        RndReadyxSI,
    output logic [2*SHARES*(SHARES-1)-1:0]              Z1xDO,
    output logic [2*SHARES*(SHARES-1)-1:0]              Z2xDO,
    output logic [SHARES*(SHARES-1)-1:0]                ZxDO,
    output logic [4*nb(SHARES,FIRST_ORDER_OPTIMIZATION)-1:0] BxDO,
    output logic                                        ErrorxSO
);

    localparam int NB   = nb(SHARES, FIRST_ORDER_OPTIMIZATION);
    localparam int RW   = rw(SHARES, FIRST_ORDER_OPTIMIZATION);
    localparam int NL   = nl(SHARES, FIRST_ORDER_OPTIMIZATION);
    localparam int ZW   = SHARES * (SHARES - 1);
    localparam int WU   = (WARMUP < 1) ? 1 : WARMUP;
    localparam int IDXW = (NL > 1) ? $clog2(NL) : 1;

    // Seed and bundle ports are both valid/ready: a word or bundle moves on
    // a clock edge where valid and ready are high together; valid never
    // depends on ready.
    dom_rand_state_e state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [31:0]     warm_q, warm_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            seed_ready, rnd_valid;
    logic            seed_fire, rnd_fire;
    logic            load_any, adv_all;
    logic [NL*32-1:0] pool;
    logic [NL-1:0]   lane_hit;

    assign seed_fire = SeedValidxSI & seed_ready;
    assign rnd_fire  = rnd_valid & RndReadyxSI;

`ifdef DOM_RAND_HEALTH_EN
    logic error_q, error_d;
`endif

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            state_q <= ST_SEED;
            idx_q   <= '0;
            warm_q  <= '0;
            cnt_q   <= '0;
`ifdef DOM_RAND_HEALTH_EN
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            warm_q  <= warm_d;
            cnt_q   <= cnt_d;
`ifdef DOM_RAND_HEALTH_EN
            error_q <= error_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        warm_d   = warm_q;
        cnt_d    = cnt_q;
        load_any = 1'b0;
        adv_all  = 1'b0;
`ifdef DOM_RAND_HEALTH_EN
        error_d  = error_q;
`endif
        case (state_q)
            ST_SEED: begin
                if (seed_fire) begin
                    load_any = 1'b1;
                    if (idx_q == IDXW'(NL - 1)) begin
                        idx_d   = '0;
                        warm_d  = '0;
                        state_d = ST_WARM;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            ST_WARM: begin
                adv_all = 1'b1;
                warm_d  = warm_q + 32'd1;
                if (warm_d == 32'(WU)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (rnd_fire) begin
                    adv_all = 1'b1;
                    cnt_d   = cnt_q + 32'd1;
                    if (RESEED_INTERVAL != 0 && cnt_d == 32'(RESEED_INTERVAL)) begin
                        state_d = ST_SEED;
                    end
                end
                if (ReseedxSI) begin
                    state_d = ST_SEED;
                end
            end
            default: ;
        endcase
`ifdef DOM_RAND_HEALTH_EN
        if ((state_q == ST_WARM || state_q == ST_RUN) && (|lane_hit)) begin
            error_d = 1'b1;
            state_d = ST_ERROR;
        end
`endif
    end

    always_comb begin
        seed_ready = 1'b0;
        rnd_valid  = 1'b0;
        case (state_q)
            ST_SEED: seed_ready = 1'b1;
            ST_RUN:  rnd_valid  = 1'b1;
            default: ;
        endcase
    end

    assign SeedReadyxSO = seed_ready;
    assign RndValidxSO  = rnd_valid;

`ifdef DOM_RAND_HEALTH_EN
    assign ErrorxSO = error_q;
`else
    assign ErrorxSO = 1'b0;
    logic unused_lane_hit;
    assign unused_lane_hit = |lane_hit;
`endif

    for (genvar g = 0; g < NL; g++) begin : g_lane
        dom_xorshift32_lane u_lane (
            .clk_i        (ClkxCI),
            .rst_i        (RstxRI),
            .load_en_i    (load_any && (idx_q == IDXW'(g))),
            .load_val_i   (SeedxDI),
            .adv_en_i     (adv_all),
            .lane_o       (pool[g*32 +: 32]),
            .health_err_o (lane_hit[g])
        );
    end

    // Bundles are sliced LSB-first straight from the lane registers.
    assign BxDO  = pool[4*NB-1:0];
    assign ZxDO  = pool[4*NB +: ZW];
    assign Z1xDO = pool[4*NB+ZW +: 2*ZW];
    assign Z2xDO = pool[4*NB+3*ZW +: 2*ZW];

    if (NL * 32 > RW) begin : g_pool_tail
        logic unused_pool_tail;
        assign unused_pool_tail = ^pool[NL*32-1:RW];
    end

endmodule

// File: tb/tb_dom_rand_source.sv
// Directed bench for dom_rand_source: a SHARES=2 single-lane instance and a
// SHARES=3 two-lane instance sharing one clock.
module tb_dom_rand_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: SHARES=2, NB=1, RW=14, NL=1, WARMUP=1, RESEED_INTERVAL=3
    logic        rst_a, seed_valid_a, seed_ready_a, reseed_a;
    logic        rnd_valid_a, rnd_ready_a, err_a;
    logic [31:0] seed_a;
    logic [3:0]  z1_a, z2_a, b_a;
    logic [1:0]  z_a;
    logic [13:0] bun_a;
    assign bun_a = {z2_a, z1_a, z_a, b_a};

    // Instance B: SHARES=3, NB=3, RW=42, NL=2, WARMUP=1
    logic        rst_b, seed_valid_b, seed_ready_b, reseed_b;
    logic        rnd_valid_b, rnd_ready_b, err_b;
    logic [31:0] seed_b;
    logic [11:0] z1_b, z2_b, b_b;
    logic [5:0]  z_b;

    dom_rand_source #(
        .SHARES(2), .FIRST_ORDER_OPTIMIZATION(1), .RESEED_INTERVAL(3), .WARMUP(1)
    ) u_dut_a (
        .ClkxCI(clk), .RstxRI(rst_a), .SeedxDI(seed_a), .SeedValidxSI(seed_valid_a),
        .SeedReadyxSO(seed_ready_a), .ReseedxSI(reseed_a), .RndValidxSO(rnd_valid_a),
        .RndReadyxSI(rnd_ready_a), .Z1xDO(z1_a), .Z2xDO(z2_a), .ZxDO(z_a), .BxDO(b_a),
        .ErrorxSO(err_a)
    );

    dom_rand_source #(
        .SHARES(3), .FIRST_ORDER_OPTIMIZATION(1), .RESEED_INTERVAL(1024), .WARMUP(1)
    ) u_dut_b (
        .ClkxCI(clk), .RstxRI(rst_b), .SeedxDI(seed_b), .SeedValidxSI(seed_valid_b),
        .SeedReadyxSO(seed_ready_b), .ReseedxSI(reseed_b), .RndValidxSO(rnd_valid_b),
        .RndReadyxSI(rnd_ready_b), .Z1xDO(z1_b), .Z2xDO(z2_b), .ZxDO(z_b), .BxDO(b_b),
        .ErrorxSO(err_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference xorshift32 step used for the longer chains.
    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    logic [31:0] exp_lane;
    int          fires;

    initial begin
        rst_a = 1'b1; seed_valid_a = 1'b0; seed_a = '0; reseed_a = 1'b0; rnd_ready_a = 1'b0;
        rst_b = 1'b1; seed_valid_b = 1'b0; seed_b = '0; reseed_b = 1'b0; rnd_ready_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        // Reset state
        check_eq("rst_seed_ready_a", 64'(seed_ready_a), 64'(1));
        check_eq("rst_valid_a",      64'(rnd_valid_a),  64'(0));
        check_eq("rst_bundle_a",     64'(bun_a),        64'(0));
        check_eq("rst_err_a",        64'(err_a),        64'(0));
        check_eq("rst_seed_ready_b", 64'(seed_ready_b), 64'(1));
        check_eq("rst_valid_b",      64'(rnd_valid_b),  64'(0));
        check_eq("rst_bundle_b",     64'({z2_b, z1_b, z_b, b_b}), 64'(0));
        check_eq("rst_err_b",        64'(err_b),        64'(0));

        // Seed 1: lane becomes 0x00042021 after one warm-up advance
        seed_valid_a = 1'b1; seed_a = 32'h1;
        @(negedge clk);
        seed_valid_a = 1'b0;
        check_eq("warm_seed_ready_a", 64'(seed_ready_a), 64'(0));
        check_eq("warm_valid_a",      64'(rnd_valid_a),  64'(0));
        @(negedge clk);
        check_eq("first_valid_a", 64'(rnd_valid_a), 64'(1));
        check_eq("first_b_a",     64'(b_a),  64'(4'h1));
        check_eq("first_z_a",     64'(z_a),  64'(2'b10));
        check_eq("first_z1_a",    64'(z1_a), 64'(4'h0));
        check_eq("first_z2_a",    64'(z2_a), 64'(4'h8));

        // Hold with ready low
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("hold_a", 64'({rnd_valid_a, bun_a}), 64'({1'b1, 14'h2021}));
        end

        // One ready pulse: xs32(0x00042021) = 0x04080601
        rnd_ready_a = 1'b1;
        @(negedge clk);
        rnd_ready_a = 1'b0;
        check_eq("step_b_a",  64'(b_a),  64'(4'h1));
        check_eq("step_z_a",  64'(z_a),  64'(2'b00));
        check_eq("step_z1_a", 64'(z1_a), 64'(4'h8));
        check_eq("step_z2_a", 64'(z2_a), 64'(4'h1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("step_hold_a", 64'(bun_a), 64'(14'h0601));
        end

        // Reseed pulse coinciding with a fire: advance honoured, SEED next
        rnd_ready_a = 1'b1; reseed_a = 1'b1;
        @(negedge clk);
        rnd_ready_a = 1'b0; reseed_a = 1'b0;
        exp_lane = xs32(32'h04080601);
        check_eq("reseed_valid_a",      64'(rnd_valid_a),  64'(0));
        check_eq("reseed_seed_ready_a", 64'(seed_ready_a), 64'(1));
        check_eq("reseed_fire_a",       64'(bun_a),        64'(exp_lane[13:0]));

        // Zero seed word is replaced by the substitute constant
        seed_valid_a = 1'b1; seed_a = 32'h0;
        @(negedge clk);
        seed_valid_a = 1'b0;
        check_eq("zseed_warm_valid_a", 64'(rnd_valid_a), 64'(0));
        @(negedge clk);
        exp_lane = xs32(32'h2545F491);
        check_eq("zseed_valid_a",   64'(rnd_valid_a), 64'(1));
        check_eq("zseed_bundle_a",  64'(bun_a),       64'(exp_lane[13:0]));
        check_eq("zseed_nonzero_a", 64'(bun_a != 14'h0), 64'(1));

        // Reseed interval of 3: exactly three bundles with ready held high
        rnd_ready_a = 1'b1;
        fires = 0;
        for (int i = 0; i < 20; i++) begin
            if (!rnd_valid_a) break;
            check_eq("interval_bundle_a", 64'(bun_a), 64'(exp_lane[13:0]));
            exp_lane = xs32(exp_lane);
            fires++;
            @(negedge clk);
        end
        rnd_ready_a = 1'b0;
        check_eq("interval_fires_a",      64'(fires),        64'(3));
        check_eq("interval_seed_ready_a", 64'(seed_ready_a), 64'(1));
        check_eq("interval_valid_a",      64'(rnd_valid_a),  64'(0));

`ifdef DOM_RAND_HEALTH_EN
        // Stuck lane: force the xorshift fixed point and fire once
        seed_valid_a = 1'b1; seed_a = 32'h1;
        @(negedge clk);
        seed_valid_a = 1'b0;
        @(negedge clk);
        check_eq("health_pre_valid_a", 64'(rnd_valid_a), 64'(1));
        force u_dut_a.g_lane[0].u_lane.lane_q = 32'h0;
        rnd_ready_a = 1'b1;
        @(negedge clk);
        rnd_ready_a = 1'b0;
        release u_dut_a.g_lane[0].u_lane.lane_q;
        check_eq("health_err_a",        64'(err_a),        64'(1));
        check_eq("health_valid_a",      64'(rnd_valid_a),  64'(0));
        check_eq("health_seed_ready_a", 64'(seed_ready_a), 64'(0));
        repeat (3) @(negedge clk);
        check_eq("health_sticky_a", 64'({err_a, rnd_valid_a, seed_ready_a}), 64'(3'b100));
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check_eq("health_clear_a", 64'({err_a, seed_ready_a}), 64'(2'b01));
`endif

        // Instance B: one word, then reset discards it
        seed_valid_b = 1'b1; seed_b = 32'hDEADBEEF;
        @(negedge clk);
        seed_valid_b = 1'b0;
        check_eq("partial_seed_ready_b", 64'(seed_ready_b), 64'(1));
        check_eq("partial_valid_b",      64'(rnd_valid_b),  64'(0));
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check_eq("midrst_seed_ready_b", 64'(seed_ready_b), 64'(1));
        check_eq("midrst_bundle_b",     64'({z2_b, z1_b, z_b, b_b}), 64'(0));

        // Seed words 1 then 2 go to lane 0 then lane 1
        seed_valid_b = 1'b1; seed_b = 32'h1;
        @(negedge clk);
        seed_b = 32'h2;
        check_eq("word1_seed_ready_b", 64'(seed_ready_b), 64'(1));
        @(negedge clk);
        seed_valid_b = 1'b0;
        check_eq("word2_seed_ready_b", 64'(seed_ready_b), 64'(0));
        check_eq("word2_valid_b",      64'(rnd_valid_b),  64'(0));
        @(negedge clk);
        // P = {0x00084042, 0x00042021}
        check_eq("run_valid_b", 64'(rnd_valid_b), 64'(1));
        check_eq("run_b_b",     64'(b_b),  64'(12'h021));
        check_eq("run_z_b",     64'(z_b),  64'(6'h02));
        check_eq("run_z1_b",    64'(z1_b), 64'(12'h001));
        check_eq("run_z2_b",    64'(z2_b), 64'(12'h108));
        check_eq("run_err_b",   64'(err_b), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dom_rand_source.md
Name: dom_rand_source

Overview:
- Produces the fresh randomness consumed by the DOM shared multiplier stages: Z1, Z2 and Z remask bundles, plus the B blinding bundle.
- One complete randomness bundle is delivered per accepted valid/ready transfer.
- Built from NL 32-bit xorshift32 lanes. The lanes are seeded through a word-serial seed port and reseeded periodically.
- Sits between the system TRNG/seed source and the S-box stage pipeline.

Parameters:
- SHARES, 2: number of masking shares; determines all bundle widths.
- FIRST_ORDER_OPTIMIZATION, 1: 1 selects NB=1 blinding nibble when SHARES==2; otherwise NB=SHARES.
- RESEED_INTERVAL, 1024: number of bundle transfers between automatic reseeds; 0 disables automatic reseeding.
- WARMUP, 4: number of silent lane advances after seeding, before the first output (minimum 1).

Ports:
- ClkxCI, in, 1: clock.
- RstxRI, in, 1: reset, synchronous, active-high.
- SeedxDI, in, 32: seed word.
- SeedValidxSI, in, 1: seed word valid.
- SeedReadyxSO, out, 1: seed word accepted when high together with SeedValidxSI.
- ReseedxSI, in, 1: one-cycle pulse forcing a reseed.
- RndValidxSO, out, 1: bundle valid.
- RndReadyxSI, in, 1: consumer ready.
- Z1xDO, out, 2*SHARES*(SHARES-1): remask bundle for multiplier 1.
- Z2xDO, out, 2*SHARES*(SHARES-1): remask bundle for multiplier 2.
- ZxDO, out, SHARES*(SHARES-1): remask bundle for the GF(2^2) multiplier.
- BxDO, out, 4*NB: blinding bundle.
- ErrorxSO, out, 1: health error flag (see Optional Feature).

Behaviour:
- Widths:
  - RW = 5*SHARES*(SHARES-1) + 4*NB.
  - NL = ceil(RW/32).
  - Pool P = {lane[NL-1], ..., lane[0]}; only P[RW-1:0] is used.
- Mapping, LSB first:
  - BxDO = P[4NB-1:0]
  - ZxDO = next SHARES*(SHARES-1) bits
  - Z1xDO = next 2*SHARES*(SHARES-1) bits
  - Z2xDO = next 2*SHARES*(SHARES-1) bits
- Lane advance, combinational from the lane register x: x^=x<<13; x^=x>>17; x^=x<<5.
- Outputs are taken directly from the lane registers, so they are registered values.
- Reset state: FSM=SEED, lanes=0, word index=0, counters=0. All outputs are 0 except SeedReadyxSO, which is 1 in SEED.
- FSM states:
  - SEED:
    - SeedReadyxSO=1.
    - Each seed fire loads lane[idx]; a zero word is replaced by 32'h2545F491; idx increments.
    - On the fire that loads lane NL-1: idx<=0, warm counter<=0, go to WARM.
  - WARM:
    - All lanes advance every cycle.
    - After WARMUP advances, go to RUN with the reseed counter cleared.
  - RUN:
    - RndValidxSO=1.
    - On a fire (RndValidxSO & RndReadyxSI): all lanes advance and the counter increments.
    - Without a fire: outputs hold stable; lanes do not change.
    - If RESEED_INTERVAL!=0 and the fire makes counter==RESEED_INTERVAL, go to SEED. RndValidxSO is 0 from the next cycle.
    - ReseedxSI in RUN: go to SEED next cycle. A fire in that same cycle is still honoured.
  - ERROR: only with the optional feature enabled.
- ReseedxSI in SEED or WARM is ignored.
- The first bundle is visible 1+WARMUP cycles after the last seed fire.
- Reset asserted mid-seed or mid-run returns the block to the reset state on the next edge; partially loaded seeds are discarded.
- Lanes are never zero while in RUN, because zero seed words are substituted.

Optional Feature:
- Macro: DOM_RAND_HEALTH_EN.
- Enabled:
  - Each lane holds a copy of its previous value.
  - If any lane's advance in WARM or RUN yields a value equal to the lane's value before the advance, ErrorxSO is set (sticky).
  - The FSM enters ERROR; RndValidxSO=0 and SeedReadyxSO=0 until reset.
- Disabled: ErrorxSO is tied 0, there is no ERROR state, and the compare logic is not built.

Decomposition:
- Package dom_rand_pkg holds:
  - the FSM state enum;
  - the xorshift shift constants 13/17/5;
  - the zero-seed substitute 32'h2545F491;
  - width functions: nb(SHARES, FOO), rw(...), nl(...).
- One sub-module, dom_xorshift32_lane: 32-bit register with load, advance, and optional health compare.
- The top level holds the FSM, counters and bit mapping.

Test Plan:
- SHARES=2, FOO=1, WARMUP=1, seed 32'h00000001 -> RW=14, NL=1:
  - lane = 32'h00042021;
  - BxDO=4'h1, ZxDO=2'b10, Z1xDO=4'h0, Z2xDO=4'h8;
  - RndValidxSO rises 2 cycles after the seed fire.
- Seed word 32'h0 -> lane loads 32'h2545F491; no stuck output; RndValidxSO asserted after warm-up.
- RUN with RndReadyxSI=0 for 10 cycles -> outputs constant. One ready pulse -> exactly one advance.
- RESEED_INTERVAL=3, RndReadyxSI=1 -> exactly 3 bundles, then RndValidxSO=0 and SeedReadyxSO=1.
- ReseedxSI pulse in RUN together with a fire -> fire counted, SEED entered next cycle. RstxRI asserted mid-seed with SHARES=3 (NL=2) after one word -> back to SEED with idx=0.
- With DOM_RAND_HEALTH_EN, lane register forced to a fixed point via testbench force -> ErrorxSO=1 and RndValidxSO=0 until RstxRI.
